mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, defined as the maximum number of consecutive data-port wins while an instruction-fetch request is pending.
REQ-002 The block SHALL have parameter ADDR_W, default 32, defined as the address width of all ports.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, exposed as ports clk_i and rst_i.
REQ-004 clk_i  in  1  clock; all state changes on the rising edge.
REQ-005 rst_i  in  1  synchronous reset, active-high.
REQ-006 if_req_i  in  1  fetch read request, held until if_gnt_o; if_addr_i  in  ADDR_W  fetch address.
REQ-007 if_gnt_o  out  1  fetch address accepted (1-cycle pulse); if_rvalid_o  out  1  fetch data valid (1-cycle pulse); if_rdata_o  out  32  fetch data.
REQ-008 dm_req_i  in  1  data request, held until dm_gnt_o; dm_addr_i  in  ADDR_W  data address.
REQ-009 dm_we_i  in  4  byte write enables (0000 means read); dm_wdata_i  in  32  write data.
REQ-010 dm_gnt_o  out  1  data request accepted (pulse); dm_rvalid_o  out  1  read data valid (pulse); dm_rdata_o  out  32  read data.
REQ-011 mem_req_o  out  1  request to memory; mem_addr_o  out  ADDR_W; mem_we_o  out  4; mem_wdata_o  out  32; mem_ready_i  in  1  memory accepts the request.
REQ-012 mem_rvalid_i  in  1  memory read data valid; mem_rdata_i  in  32  memory read data.
REQ-013 perf_conflict_o  out  32  count of cycles in which both requests were pending in IDLE; perf_wait_o  out  32  count of cycles spent in REQ or WAIT.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, REQ, WAIT.
REQ-015 In IDLE with any request pending, the block SHALL latch the winner's address, write enables, write data and owner, and SHALL move to REQ on the next edge.
REQ-016 Arbitration SHALL give the data port priority, except that fetch SHALL win when starve_cnt == STARVE_LIMIT.
REQ-017 starve_cnt SHALL increment, saturating, on each data win while if_req_i=1; it SHALL clear on a fetch win or whenever if_req_i=0 in IDLE.
REQ-018 In REQ, mem_req_o=1 and mem_* SHALL carry the latched values.
REQ-019 On mem_ready_i in REQ, the block SHALL pulse the owner's gnt_o in that same cycle.
REQ-020 On mem_ready_i in REQ, a write SHALL go to IDLE and a read SHALL go to WAIT.
REQ-021 If mem_rvalid_i coincides with mem_ready_i on a read, the block SHALL complete the read and go directly to IDLE.
REQ-022 On mem_rvalid_i in WAIT, the block SHALL register mem_rdata_i into the owner's rdata_o and pulse the owner's rvalid_o on the following cycle, then go to IDLE.
REQ-023 rdata_o SHALL hold its value until the next read completes.
REQ-024 Only one transaction SHALL be outstanding at a time.
REQ-025 mem_rvalid_i in IDLE or REQ SHALL be ignored.
REQ-026 mem_req_o SHALL be 0 in IDLE and WAIT.
REQ-027 A new request SHALL be arbitrable in the cycle the FSM re-enters IDLE, giving a minimum of 2 cycles between consecutive grants.
REQ-028 Requests deasserted before grant SHALL be dropped without side effects while the FSM is in IDLE; requests are not re-sampled after the latch.

Reset
REQ-029 On rst_i=1 the block SHALL force the FSM to IDLE and clear starve_cnt, all gnt and rvalid outputs, rdata_o, mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o and the perf counters to 0.
REQ-030 An in-flight transaction SHALL be abandoned on reset; a late mem_rvalid_i after reset SHALL be ignored.

Configuration
REQ-031 With macro MEM_ARB_PERF_EN defined, perf_conflict_o and perf_wait_o SHALL count as specified in REQ-013, wrapping modulo 2^32.
REQ-032 Without MEM_ARB_PERF_EN, perf_conflict_o and perf_wait_o SHALL be constant 0 and no counter flops SHALL be synthesised.

Structure
REQ-033 The shared CPU package SHALL hold the arb_state_e enum (IDLE, REQ, WAIT), the arb_owner_e enum (OWN_IF, OWN_DM), and constant WE_NONE = 4'b0000.
REQ-034 The counters SHALL live in one sub-module, mem_arb_perf, instantiated only under MEM_ARB_PERF_EN.

Verification
REQ-035 Fetch-only read: if_req_i=1, if_addr_i=0x100, mem_ready_i on the first REQ cycle, mem_rvalid_i 2 cycles later with rdata 0xDEADBEEF -> if_gnt_o pulses once; if_rvalid_o pulses with if_rdata_o=0xDEADBEEF one cycle after mem_rvalid_i.
REQ-036 Simultaneous requests: if_req_i and dm_req_i (dm_we_i=1111, addr 0x200, wdata 0x12345678) -> data is granted first with mem_we_o=1111, then fetch; no dm_rvalid_o pulse.
REQ-037 Starvation with STARVE_LIMIT=4: dm_req_i and if_req_i held high continuously -> exactly 4 data grants, then 1 fetch grant, then the pattern repeats.
REQ-038 Coincident ready/rvalid: a data read with mem_ready_i=1 and mem_rvalid_i=1 in the same cycle -> WAIT is skipped; dm_rvalid_o pulses on the next cycle.
REQ-039 Reset mid-read: rst_i=1 while in WAIT, then mem_rvalid_i=1 -> no rvalid pulse and the FSM is in IDLE.
REQ-040 Counters, with and without MEM_ARB_PERF_EN: 3 conflict cycles -> perf_conflict_o=3 with the macro defined, and 0 without it.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction-fetch / data-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/mem_arb_perf.sv
// Performance counters for mem_arbiter; only built when MEM_ARB_PERF_EN is defined,
// so the default build carries no counter logic at all.
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        conflict_i,
  input  logic        busy_i,
  output logic [31:0] perf_conflict_o,
  output logic [31:0] perf_wait_o
);

  // Free-running event counters, wrapping naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_conflict_o <= 32'd0;
      perf_wait_o     <= 32'd0;
    end else begin
      if (conflict_i) perf_conflict_o <= perf_conflict_o + 32'd1;
      if (busy_i)     perf_wait_o     <= perf_wait_o + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) single-outstanding memory arbiter with fetch anti-starvation.
// Optional performance counters are enabled with macro MEM_ARB_PERF_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              dm_req_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [3:0]        dm_we_i,
  input  logic [31:0]       dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [31:0]       dm_rdata_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_we_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       perf_conflict_o,
  output logic [31:0]       perf_wait_o
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_r, state_nxt;
  arb_owner_e        owner_r;
  logic [CNT_W-1:0]  starve_cnt_r, starve_nxt;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        we_r;
  logic [31:0]       wdata_r;
  logic              if_rvalid_r, dm_rvalid_r;
  logic [31:0]       if_rdata_r, dm_rdata_r;
  logic              latch_en, pick_if, gnt, rd_done;
  logic              starve_hit;

  assign starve_hit = (starve_cnt_r == CNT_MAX);

  // Next-state, arbitration and handshake decode.
  always_comb begin
    state_nxt = state_r;
    latch_en  = 1'b0;
    pick_if   = 1'b0;
    gnt       = 1'b0;
    rd_done   = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          latch_en  = 1'b1;
          pick_if   = if_req_i && (!dm_req_i || starve_hit);
          state_nxt = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (mem_ready_i) begin
          gnt = 1'b1;
          if (we_r != WE_NONE) begin
            state_nxt = IDLE;
          end else if (mem_rvalid_i) begin
            // read data arrived together with the accept: no need to wait
            rd_done   = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end else begin
          state_nxt = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Starvation counter: counts data wins over a waiting fetch, saturating at the limit.
  always_comb begin
    starve_nxt = starve_cnt_r;
    if (state_r == IDLE) begin
      if (!if_req_i || pick_if) begin
        starve_nxt = '0;
      end else if (!starve_hit) begin
        starve_nxt = starve_cnt_r + CNT_W'(1);
      end else begin
        starve_nxt = starve_cnt_r;
      end
    end else begin
      starve_nxt = starve_cnt_r;
    end
  end

  // FSM state and starvation counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      starve_cnt_r <= '0;
    end else begin
      state_r      <= state_nxt;
      starve_cnt_r <= starve_nxt;
    end
  end

  // Latched transaction and per-port read return registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_r     <= OWN_IF;
      addr_r      <= '0;
      we_r        <= WE_NONE;
      wdata_r     <= 32'd0;
      if_rvalid_r <= 1'b0;
      dm_rvalid_r <= 1'b0;
      if_rdata_r  <= 32'd0;
      dm_rdata_r  <= 32'd0;
    end else begin
      if (latch_en) begin
        owner_r <= pick_if ? OWN_IF : OWN_DM;
        addr_r  <= pick_if ? if_addr_i : dm_addr_i;
        we_r    <= pick_if ? WE_NONE : dm_we_i;
        wdata_r <= pick_if ? 32'd0 : dm_wdata_i;
      end
      if_rvalid_r <= rd_done && (owner_r == OWN_IF);
      dm_rvalid_r <= rd_done && (owner_r == OWN_DM);
      if (rd_done && (owner_r == OWN_IF)) if_rdata_r <= mem_rdata_i;
      if (rd_done && (owner_r == OWN_DM)) dm_rdata_r <= mem_rdata_i;
    end
  end

  assign if_gnt_o    = gnt && (owner_r == OWN_IF);
  assign dm_gnt_o    = gnt && (owner_r == OWN_DM);
  assign if_rvalid_o = if_rvalid_r;
  assign dm_rvalid_o = dm_rvalid_r;
  assign if_rdata_o  = if_rdata_r;
  assign dm_rdata_o  = dm_rdata_r;
  assign mem_req_o   = (state_r == REQ);
  assign mem_addr_o  = addr_r;
  assign mem_we_o    = we_r;
  assign mem_wdata_o = wdata_r;

`ifdef MEM_ARB_PERF_EN
  logic conflict, busy;
  assign conflict = (state_r == IDLE) && if_req_i && dm_req_i;
  assign busy     = (state_r == REQ) || (state_r == WAIT);

  mem_arb_perf u_perf (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .conflict_i      (conflict),
    .busy_i          (busy),
    .perf_conflict_o (perf_conflict_o),
    .perf_wait_o     (perf_wait_o)
  );
`else
  assign perf_conflict_o = 32'd0;
  assign perf_wait_o     = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants/read returns are queued as
// stimulus is issued and popped when the DUT pulses gnt/rvalid.
module tb_mem_arbiter;

  typedef struct packed {
    logic        own_dm;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic        own_dm;
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0, dm_req_i = 1'b0;
  logic [31:0] if_addr_i = 32'h0, dm_addr_i = 32'h0, dm_wdata_i = 32'h0;
  logic [3:0]  dm_we_i = 4'h0;
  logic        mem_ready_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_we_o;
  logic [31:0] perf_conflict_o, perf_wait_o;

  int total = 0, bad = 0, cyc = 0;
  int if_cnt = 0, dm_cnt = 0, rv_delay = 1, rv_timer = 0;
  logic [3:0]  dm_we = 4'h0;
  logic [31:0] dm_wdata = 32'h0, acc_addr = 32'h0;
  logic        spur = 1'b0, check_gap = 1'b0, gap_first = 1'b1;
  int          last_gnt_cyc = 0;
  logic        pend_if = 1'b0, pend_dm = 1'b0;
  logic [31:0] pend_data = 32'h0, last_if_data = 32'h0, last_dm_data = 32'h0;
  gnt_t gq[$];
  rd_t  rd_q[$];

  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_we_i(dm_we_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .perf_conflict_o(perf_conflict_o), .perf_wait_o(perf_wait_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hC0DE0000);
  endfunction

  function automatic gnt_t mk(input logic own_dm, input logic [31:0] addr,
                              input logic [3:0] we, input logic [31:0] wdata);
    gnt_t g;
    g.own_dm = own_dm; g.addr = addr; g.we = we; g.wdata = wdata;
    return g;
  endfunction

  // One clock: drive requesters and memory model at negedge, then check outputs 1ns later.
  task automatic cycle();
    logic fired, exp_if, exp_dm;
    logic [31:0] exp_data;
    gnt_t e;
    rd_t  r;
    @(negedge clk);
    cyc++;
    exp_if = pend_if; exp_dm = pend_dm; exp_data = pend_data;
    pend_if = 1'b0; pend_dm = 1'b0;
    fired = 1'b0;
    if_req_i   = (if_cnt > 0);
    if_addr_i  = 32'h100 + 32'((if_cnt > 0) ? (if_cnt - 1) * 16 : 0);
    dm_req_i   = (dm_cnt > 0);
    dm_addr_i  = 32'h200 + 32'((dm_cnt > 0) ? (dm_cnt - 1) * 16 : 0);
    dm_we_i    = dm_we;
    dm_wdata_i = dm_wdata;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hBAD0BAD0;
    if (rv_timer > 0) begin
      rv_timer--;
      if (rv_timer == 0) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = data_for(acc_addr); fired = 1'b1;
      end
    end else if (mem_req_o === 1'b1) begin
      mem_ready_i = 1'b1;
      acc_addr = mem_addr_o;
      if (mem_we_o == 4'h0) begin
        if (rv_delay == 0) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = data_for(acc_addr); fired = 1'b1;
        end else begin
          rv_timer = rv_delay;
        end
      end
    end else if (spur) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h51075107;
    end
    #1;
    if (if_gnt_o === 1'b1 || dm_gnt_o === 1'b1) begin
      total++;
      if (gq.size() == 0 || (if_gnt_o && dm_gnt_o)) begin
        bad++;
        $display("FAIL gnt_unexpected: if_gnt=%0b dm_gnt=%0b queued=%0d", if_gnt_o, dm_gnt_o, gq.size());
      end else begin
        e = gq.pop_front();
        if (dm_gnt_o !== e.own_dm) begin
          bad++; $display("FAIL gnt_owner: got dm_gnt=%0b want %0b", dm_gnt_o, e.own_dm);
        end
        total++;
        if (mem_addr_o !== e.addr || mem_we_o !== e.we) begin
          bad++; $display("FAIL gnt_cmd: got addr=%h we=%b want addr=%h we=%b", mem_addr_o, mem_we_o, e.addr, e.we);
        end
        if (e.we != 4'h0) begin
          total++;
          if (mem_wdata_o !== e.wdata) begin
            bad++; $display("FAIL gnt_wdata: got %h want %h", mem_wdata_o, e.wdata);
          end
        end else begin
          r.own_dm = e.own_dm; r.data = data_for(e.addr);
          rd_q.push_back(r);
        end
        if (check_gap) begin
          if (!gap_first) begin
            total++;
            if (cyc - last_gnt_cyc != 2) begin
              bad++; $display("FAIL gnt_gap: got %0d want 2", cyc - last_gnt_cyc);
            end
          end
          gap_first = 1'b0;
          last_gnt_cyc = cyc;
        end
      end
      if (if_gnt_o === 1'b1 && if_cnt > 0) if_cnt--;
      if (dm_gnt_o === 1'b1 && dm_cnt > 0) dm_cnt--;
    end
    if (fired && rd_q.size() > 0) begin
      r = rd_q.pop_front();
      pend_if = !r.own_dm; pend_dm = r.own_dm; pend_data = r.data;
    end
    total++;
    if (if_rvalid_o !== exp_if || dm_rvalid_o !== exp_dm) begin
      bad++;
      $display("FAIL rvalid: got if=%b dm=%b want if=%b dm=%b", if_rvalid_o, dm_rvalid_o, exp_if, exp_dm);
    end
    if (exp_if) begin
      total++; last_if_data = exp_data;
      if (if_rdata_o !== exp_data) begin
        bad++; $display("FAIL if_rdata: got %h want %h", if_rdata_o, exp_data);
      end
    end
    if (exp_dm) begin
      total++; last_dm_data = exp_data;
      if (dm_rdata_o !== exp_data) begin
        bad++; $display("FAIL dm_rdata: got %h want %h", dm_rdata_o, exp_data);
      end
    end
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((gq.size() > 0 || rd_q.size() > 0 || pend_if || pend_dm || rv_timer > 0 ||
            if_cnt > 0 || dm_cnt > 0) && n < budget) begin
      cycle();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++; $display("FAIL timeout: budget=%0d gq=%0d rdq=%0d", budget, gq.size(), rd_q.size());
      gq.delete(); rd_q.delete(); if_cnt = 0; dm_cnt = 0;
    end
    cycle();
    cycle();
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    gq.delete(); rd_q.delete();
    rv_timer = 0; pend_if = 1'b0; pend_dm = 1'b0;
    cycle();
    cycle();
    last_if_data = 32'h0; last_dm_data = 32'h0;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cycle();
    cycle();
    total++;
    if ({if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, mem_req_o} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o, mem_req_o});
    end
    total++;
    if ({if_rdata_o, dm_rdata_o} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata: got %h %h want 0", if_rdata_o, dm_rdata_o);
    end
    total++;
    if ({mem_addr_o, mem_we_o, mem_wdata_o} !== 68'h0) begin
      bad++; $display("FAIL reset_mem: got %h %b %h want 0", mem_addr_o, mem_we_o, mem_wdata_o);
    end
    total++;
    if ({perf_conflict_o, perf_wait_o} !== 64'h0) begin
      bad++; $display("FAIL reset_perf: got %0d %0d want 0", perf_conflict_o, perf_wait_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_fetch_read();
    rv_delay = 2;
    gq.push_back(mk(1'b0, 32'h100, 4'h0, 32'h0));
    if_cnt = 1;
    run_until_done(40);
    total++;
    if (if_rdata_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL fetch_hold: got %h want deadbeef", if_rdata_o);
    end
  endtask

  task automatic test_simultaneous();
    rv_delay = 1; dm_we = 4'hF; dm_wdata = 32'h12345678;
    gq.push_back(mk(1'b1, 32'h200, 4'hF, 32'h12345678));
    gq.push_back(mk(1'b0, 32'h100, 4'h0, 32'h0));
    if_cnt = 1; dm_cnt = 1;
    run_until_done(40);
  endtask

  task automatic test_starvation();
    apply_reset();
    rv_delay = 1; dm_we = 4'hF; dm_wdata = 32'hA5A5A5A5;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++)
        gq.push_back(mk(1'b1, 32'h200 + 32'((7 - (k * 4 + j)) * 16), 4'hF, 32'hA5A5A5A5));
      gq.push_back(mk(1'b0, 32'h100 + 32'((1 - k) * 16), 4'h0, 32'h0));
    end
    if_cnt = 2; dm_cnt = 8;
    run_until_done(200);
  endtask

  task automatic test_coincident();
    rv_delay = 0; dm_we = 4'h0;
    check_gap = 1'b1; gap_first = 1'b1;
    gq.push_back(mk(1'b1, 32'h210, 4'h0, 32'h0));
    gq.push_back(mk(1'b1, 32'h200, 4'h0, 32'h0));
    dm_cnt = 2;
    run_until_done(40);
    check_gap = 1'b0;
  endtask

  task automatic test_back_to_back();
    rv_delay = 1; dm_we = 4'b0101; dm_wdata = 32'hCAFEF00D;
    check_gap = 1'b1; gap_first = 1'b1;
    for (int j = 0; j < 3; j++)
      gq.push_back(mk(1'b1, 32'h200 + 32'((2 - j) * 16), 4'b0101, 32'hCAFEF00D));
    dm_cnt = 3;
    run_until_done(40);
    check_gap = 1'b0;
    total++;
    if (if_rdata_o !== last_if_data || dm_rdata_o !== last_dm_data) begin
      bad++; $display("FAIL rdata_hold: got %h %h want %h %h", if_rdata_o, dm_rdata_o, last_if_data, last_dm_data);
    end
  endtask

  task automatic test_spurious();
    spur = 1'b1;
    for (int j = 0; j < 4; j++) cycle();
    spur = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    rv_delay = 4; dm_we = 4'h0;
    gq.push_back(mk(1'b1, 32'h200, 4'h0, 32'h0));
    dm_cnt = 1;
    while (gq.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++; $display("FAIL midread_gnt: no grant within %0d cycles", n);
    end
    cycle();
    rst_i = 1'b1;
    rd_q.delete();
    cycle();
    rst_i = 1'b0;
    last_if_data = 32'h0; last_dm_data = 32'h0;
    run_until_done(20);
    total++;
    if (mem_req_o !== 1'b0 || dm_rdata_o !== 32'h0 || mem_addr_o !== 32'h0) begin
      bad++; $display("FAIL midread_state: got req=%b rdata=%h addr=%h want 0 0 0", mem_req_o, dm_rdata_o, mem_addr_o);
    end
    rv_delay = 1;
    gq.push_back(mk(1'b0, 32'h100, 4'h0, 32'h0));
    if_cnt = 1;
    run_until_done(40);
  endtask

  task automatic test_perf();
    logic [31:0] want_c, want_w;
`ifdef MEM_ARB_PERF_EN
    want_c = 32'd3; want_w = 32'd6;
`else
    want_c = 32'd0; want_w = 32'd0;
`endif
    apply_reset();
    rv_delay = 2; dm_we = 4'hF; dm_wdata = 32'h0BADF00D;
    for (int j = 0; j < 3; j++)
      gq.push_back(mk(1'b1, 32'h200 + 32'((2 - j) * 16), 4'hF, 32'h0BADF00D));
    gq.push_back(mk(1'b0, 32'h100, 4'h0, 32'h0));
    if_cnt = 1; dm_cnt = 3;
    run_until_done(60);
    total++;
    if (perf_conflict_o !== want_c) begin
      bad++; $display("FAIL perf_conflict: got %0d want %0d", perf_conflict_o, want_c);
    end
    total++;
    if (perf_wait_o !== want_w) begin
      bad++; $display("FAIL perf_wait: got %0d want %0d", perf_wait_o, want_w);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_starvation();
    test_coincident();
    test_back_to_back();
    test_spurious();
    test_reset_mid_read();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
